// File: rtl/lsu_pkg.sv
// Shared LSU types: funct3 width codes, response error codes, FSM state encoding.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'd0,
    F3_H  = 3'd1,
    F3_W  = 3'd2,
    F3_BU = 3'd4,
    F3_HU = 3'd5
  } funct3_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_ILLEGAL  = 2'd3
  } err_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } state_e;

  // Error priority: illegal code first, then alignment, then range.
  // funct3[1:0] encodes access size for every legal code (0=byte, 1=half, 2=word).
  function automatic err_e req_error(input logic        store,
                                     input logic [2:0]  f3,
                                     input logic [31:0] addr,
                                     input logic [31:0] depth);
    logic legal;
    if (store) legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else       legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
    if (!legal) return ERR_ILLEGAL;
    if ((f3[1:0] == 2'd1) && addr[0]) return ERR_MISALIGN;
    if ((f3[1:0] == 2'd2) && (addr[1:0] != 2'b00)) return ERR_MISALIGN;
    if ({2'b00, addr[31:2]} >= depth) return ERR_RANGE;
    return ERR_OK;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
// Latency: purely combinational.
// Backpressure: none.
// Ports: rdata (memory word), off (byte offset), funct3 (width/sign),
//        wdata (low 16 bits of store data) -> load_data (extended), merged (word with lane replaced).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  b;
  logic [15:0] h;

  assign bsh = {off, 3'b000};
  assign hsh = {off[1], 4'b0000};
  assign b   = rdata[bsh +: 8];
  assign h   = rdata[hsh +: 16];

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = {{24{b[7]}}, b};
      F3_BU:   load_data = {24'h0, b};
      F3_H:    load_data = {{16{h[15]}}, h};
      F3_HU:   load_data = {16'h0, h};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    merged = rdata;
    if (funct3[1:0] == 2'd0)      merged[bsh +: 8]  = wdata[7:0];
    else if (funct3[1:0] == 2'd1) merged[hsh +: 16] = wdata;
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: RV32I loads/stores to a word memory, sub-word stores via read-merge-write.
// Latency: response 1 cycle after acceptance (SB/SH: 2 cycles, write in the second).
// Backpressure: req_ready low only during the MERGE cycle of SB/SH; req_* ignored then.
// Ports: req_* pipeline request, resp_* completion pulse with data/error,
//        mem_* word-indexed data memory with combinational read data.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_e      state, state_nxt;
  err_e        err;
  logic        accept;
  logic        is_sub;
  logic [31:0] load_data, merged;
  logic [31:0] merge_word, merge_addr;
  logic        capture;
  logic        resp_valid_nxt;
  logic [31:0] resp_rdata_nxt;
  logic [1:0]  resp_err_nxt;

  assign req_ready = (state == ST_IDLE);
  // Gating with reset keeps every memory strobe low while reset is held.
  assign accept    = req_valid && req_ready && reset;
  assign err       = req_error(req_store, req_funct3, req_addr, DEPTH_W);
  assign is_sub    = (req_funct3[1:0] != 2'd2);

  lsu_align u_align (
    .rdata     (mem_rdata),
    .off       (req_addr[1:0]),
    .funct3    (req_funct3),
    .wdata     (req_wdata[15:0]),
    .load_data (load_data),
    .merged    (merged)
  );

  always_comb begin
    state_nxt      = state;
    mem_we         = 1'b0;
    mem_re         = 1'b0;
    mem_wdata      = 32'h0;
    mem_addr       = 32'h0;
    capture        = 1'b0;
    resp_valid_nxt = 1'b0;
    resp_rdata_nxt = 32'h0;
    resp_err_nxt   = ERR_OK;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          resp_err_nxt = err;
          if (err != ERR_OK) begin
            resp_valid_nxt = 1'b1;
          end else if (!req_store) begin
            mem_addr       = {2'b00, req_addr[31:2]};
            mem_re         = 1'b1;
            resp_valid_nxt = 1'b1;
            resp_rdata_nxt = load_data;
          end else if (!is_sub) begin
            mem_addr       = {2'b00, req_addr[31:2]};
            mem_we         = 1'b1;
            mem_wdata      = req_wdata;
            resp_valid_nxt = 1'b1;
          end else begin
            // Sub-word store: read old word now, write merged word next cycle.
            mem_addr  = {2'b00, req_addr[31:2]};
            mem_re    = 1'b1;
            capture   = 1'b1;
            state_nxt = ST_MERGE;
          end
        end
      end
      ST_MERGE: begin
        mem_addr       = merge_addr;
        mem_we         = 1'b1;
        mem_wdata      = merge_word;
        resp_valid_nxt = 1'b1;
        state_nxt      = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 2'd0;
      merge_word <= 32'h0;
      merge_addr <= 32'h0;
    end else begin
      resp_valid <= resp_valid_nxt;
      resp_rdata <= resp_rdata_nxt;
      resp_err   <= resp_err_nxt;
      if (capture) begin
        merge_word <= merged;
        merge_addr <= {2'b00, req_addr[31:2]};
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [DEPTH];
  int          we_cnt = 0;
  logic        pend_we;
  logic [31:0] pend_addr, pend_data;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  // Memory model: combinational read, write committed at the rising edge
  // using values sampled mid-cycle.
  assign mem_rdata = (mem_re && mem_addr < DEPTH) ? mem[mem_addr[5:0]] : 32'h0;

  always @(negedge clk) begin
    pend_we   <= mem_we;
    pend_addr <= mem_addr;
    pend_data <= mem_wdata;
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  always @(posedge clk) begin
    if (pend_we && pend_addr < DEPTH) mem[pend_addr[5:0]] <= pend_data;
  end

  task automatic drive(input logic v, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid  = v;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drive(1'b1, 1'b1, 3'd2, 32'h4, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if ({resp_valid, resp_err} !== 3'b000) begin errors++;
      $display("FAIL reset_resp: valid/err=%b expected 000", {resp_valid, resp_err}); end
    checks++; if (resp_rdata !== 32'h0) begin errors++;
      $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
    checks++; if ({mem_we, mem_re} !== 2'b00) begin errors++;
      $display("FAIL reset_strobes: we/re=%b expected 00", {mem_we, mem_re}); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++;
      $display("FAIL reset_mem_bus: addr=%h wdata=%h expected 0/0", mem_addr, mem_wdata); end
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++;
      $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++; if (we_cnt !== 0 || mem[1] !== 32'h1122_3344) begin errors++;
      $display("FAIL reset_no_write: we_cnt=%0d mem1=%h expected 0/11223344", we_cnt, mem[1]); end
  endtask

  task automatic test_loads;
    logic [2:0]  f3  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] ad  [4] = '{32'h0, 32'h0, 32'h2, 32'h2};
    logic [31:0] exp [4] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8000, 32'h0000_8000};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, f3[i], ad[i], 32'h0);
      #1;
      checks++; if ({req_ready, mem_re, mem_we} !== 3'b110) begin errors++;
        $display("FAIL load%0d_strobes: ready/re/we=%b expected 110", i, {req_ready, mem_re, mem_we}); end
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b1 || resp_err !== 2'd0) begin errors++;
        $display("FAIL load%0d_resp: valid=%b err=%0d expected 1/0", i, resp_valid, resp_err); end
      checks++; if (resp_rdata !== exp[i]) begin errors++;
        $display("FAIL load%0d_data: got %h expected %h", i, resp_rdata, exp[i]); end
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++;
      $display("FAIL load_idle_valid: got %b expected 0", resp_valid); end
  endtask

  task automatic test_sb_merge;
    int base;
    @(negedge clk);
    base = we_cnt;
    drive(1'b1, 1'b1, 3'd0, 32'h5, 32'h0000_00AB);
    #1;
    checks++; if ({req_ready, mem_re, mem_we} !== 3'b110) begin errors++;
      $display("FAIL sb_c1_strobes: ready/re/we=%b expected 110", {req_ready, mem_re, mem_we}); end
    @(posedge clk); #1;
    // Garbage request during MERGE must be ignored.
    drive(1'b1, 1'b1, 3'd2, 32'h4, 32'hFFFF_FFFF);
    #1;
    checks++; if ({req_ready, resp_valid, mem_we, mem_re} !== 4'b0010) begin errors++;
      $display("FAIL sb_c2_ctrl: ready/valid/we/re=%b expected 0010", {req_ready, resp_valid, mem_we, mem_re}); end
    checks++; if (mem_wdata !== 32'h1122_AB44 || mem_addr !== 32'h1) begin errors++;
      $display("FAIL sb_c2_bus: wdata=%h addr=%h expected 1122ab44/1", mem_wdata, mem_addr); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if ({resp_valid, req_ready, resp_err} !== 4'b1100 || resp_rdata !== 32'h0) begin errors++;
      $display("FAIL sb_resp: valid/ready/err=%b rdata=%h expected 1100/0", {resp_valid, req_ready, resp_err}, resp_rdata); end
    @(negedge clk); #1;
    checks++; if (we_cnt - base !== 1) begin errors++;
      $display("FAIL sb_we_count: got %0d expected 1", we_cnt - base); end
    checks++; if (mem[1] !== 32'h1122_AB44) begin errors++;
      $display("FAIL sb_word: got %h expected 1122ab44", mem[1]); end
  endtask

  task automatic test_errors;
    logic        st  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  f3  [6] = '{3'd2, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2};
    logic [31:0] ad  [6] = '{32'h6, 32'h100, 32'h0, 32'h0, 32'h1, 32'hFC};
    logic [1:0]  ee  [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd1, 2'd0};
    logic [31:0] ed  [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFE_F00D};
    logic        er  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1'b1, st[i], f3[i], ad[i], 32'h1234_5678);
      #1;
      checks++; if ({mem_we, mem_re} !== {1'b0, er[i]}) begin errors++;
        $display("FAIL err%0d_strobes: we/re=%b expected %b", i, {mem_we, mem_re}, {1'b0, er[i]}); end
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b1 || resp_err !== ee[i]) begin errors++;
        $display("FAIL err%0d_code: valid=%b err=%0d expected 1/%0d", i, resp_valid, resp_err, ee[i]); end
      checks++; if (resp_rdata !== ed[i] || req_ready !== 1'b1) begin errors++;
        $display("FAIL err%0d_data: rdata=%h ready=%b expected %h/1", i, resp_rdata, req_ready, ed[i]); end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    drive(1'b1, 1'b1, 3'd2, 32'h8, 32'hDEAD_BEEF);
    #1;
    checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h2) begin errors++;
      $display("FAIL b2b_sw_bus: we=%b wdata=%h addr=%h expected 1/deadbeef/2", mem_we, mem_wdata, mem_addr); end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b1) begin errors++;
      $display("FAIL b2b_sw_resp: valid=%b ready=%b expected 1/1", resp_valid, req_ready); end
    @(negedge clk);
    drive(1'b1, 1'b0, 3'd2, 32'h8, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL b2b_lw_data: valid=%b rdata=%h expected 1/deadbeef", resp_valid, resp_rdata); end
  endtask

  task automatic test_reset_merge;
    int base;
    @(negedge clk);
    base = we_cnt;
    drive(1'b1, 1'b1, 3'd1, 32'hC, 32'h0000_1234);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0 || mem_we !== 1'b1) begin errors++;
      $display("FAIL rm_in_merge: ready=%b we=%b expected 0/1", req_ready, mem_we); end
    reset = 1'b0;
    #1;
    checks++; if ({mem_we, mem_re, resp_valid, resp_err} !== 5'b0) begin errors++;
      $display("FAIL rm_ctrl_zero: we/re/valid/err=%b expected 00000", {mem_we, mem_re, resp_valid, resp_err}); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0) begin errors++;
      $display("FAIL rm_bus_zero: addr=%h wdata=%h rdata=%h expected 0", mem_addr, mem_wdata, resp_rdata); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || we_cnt - base !== 0) begin errors++;
      $display("FAIL rm_after: ready=%b writes=%0d expected 1/0", req_ready, we_cnt - base); end
    @(negedge clk);
    drive(1'b1, 1'b0, 3'd2, 32'hC, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h5566_7788) begin errors++;
      $display("FAIL rm_lw: valid=%b rdata=%h expected 1/55667788", resp_valid, resp_rdata); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    mem[0]  = 32'h8000_80F0;
    mem[1]  = 32'h1122_3344;
    mem[3]  = 32'h5566_7788;
    mem[63] = 32'hCAFE_F00D;
    pend_we = 1'b0;
    pend_addr = 32'h0;
    pend_data = 32'h0;
    test_reset();
    test_loads();
    test_sb_merge();
    test_errors();
    test_back_to_back();
    test_reset_merge();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 64, data-memory size in 32-bit words.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  pipeline memory request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-006 SHALL have port req_store  input  1  1=store, 0=load.
REQ-007 SHALL have port req_funct3  input  3  RV32I width/sign code: 0=B, 1=H, 2=W, 4=BU, 5=HU.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata  output  32  extended load result, valid with resp_valid.
REQ-012 SHALL have port resp_err  output  2  0=ok, 1=misaligned, 2=out-of-range, 3=illegal funct3.
REQ-013 SHALL have port mem_addr  output  32  word index to data memory (req_addr[31:2], zero-extended).
REQ-014 SHALL have port mem_wdata  output  32  full-word write data.
REQ-015 SHALL have port mem_we  output  1  memory write enable.
REQ-016 SHALL have port mem_re  output  1  memory read enable.
REQ-017 SHALL have port mem_rdata  input  32  memory read word, combinational from mem_addr/mem_re.

Function
REQ-018 SHALL implement states IDLE and MERGE; req_ready = (state==IDLE).
REQ-019 SHALL check errors at acceptance, in order: illegal funct3 (load: 3,6,7; store: anything but 0,1,2), then misaligned (H: addr[0]!=0; W: addr[1:0]!=0), then out-of-range (addr[31:2] >= DEPTH).
REQ-020 SHALL, on an erroring request, issue no memory access, stay in IDLE, and pulse resp_valid next cycle with resp_err set and resp_rdata=0.
REQ-021 SHALL, for a load accepted in IDLE, assert mem_re in the acceptance cycle, register the selected byte lane (addr[1:0]) or half lane (addr[1]) of mem_rdata, sign-extend (B, H) or zero-extend (BU, HU), and present it with resp_valid one cycle later.
REQ-022 SHALL, for SW accepted in IDLE, assert mem_we with mem_wdata=req_wdata in the acceptance cycle and pulse resp_valid one cycle later.
REQ-023 SHALL, for SB/SH accepted in IDLE, assert mem_re in the acceptance cycle, capture the old word merged with the low 8/16 bits of req_wdata in the addressed lane, and transition to MERGE.
REQ-024 SHALL, in MERGE, hold the captured word address, assert mem_we with the merged word for exactly one cycle, deassert req_ready, pulse resp_valid the next cycle, and return to IDLE.
REQ-025 SHALL keep mem_we and mem_re low in every cycle not named in REQ-021..024.
REQ-026 SHALL accept a new request in the same cycle that resp_valid is high (back-to-back): loads and SW at 1/cycle, SB/SH at 1 per 2 cycles.
REQ-027 SHALL ignore req_* inputs while req_ready is low.

Reset
REQ-028 SHALL, on reset low, immediately force state=IDLE and resp_valid, resp_rdata, resp_err, mem_we, mem_re, mem_wdata and mem_addr to 0.
REQ-029 SHALL abort a pending MERGE on reset without issuing its write.
REQ-030 SHALL assert req_ready from the first rising edge after reset release.

Structure
REQ-031 SHALL take funct3 codes, resp_err codes and the state encoding from shared package lsu_pkg.
REQ-032 SHALL place lane extraction/extension and lane merge in one combinational sub-module, lsu_align.

Verification
REQ-033 SHALL cover: memory word 0 = 0x8000_80F0; LB at 0x0 -> 0xFFFF_FFF0, LBU -> 0x0000_00F0, LH at 0x2 -> 0xFFFF_8000, LHU -> 0x0000_8000, one cycle each.
REQ-034 SHALL cover: word 1 = 0x1122_3344; SB 0xAB to 0x5 -> mem_we exactly once, in the second cycle; word 1 = 0x1122_AB44; req_ready low for one cycle.
REQ-035 SHALL cover: LW at 0x6 -> resp_err=1, no mem_we/mem_re; SW at 0x100 with DEPTH=64 -> resp_err=2; load funct3=3 -> resp_err=3.
REQ-036 SHALL cover: SW 0xDEAD_BEEF to 0x8 followed back-to-back by LW at 0x8 -> resp_rdata 0xDEAD_BEEF on the second resp_valid.
REQ-037 SHALL cover: SH to 0xC, reset asserted while in MERGE -> no mem_we, all outputs 0; after release, LW at 0xC returns the pre-store value.
